ps2_kbd_sender: RTL and testbench

Synthesizable PS/2 device-side transmitter that serializes keyboard scan codes onto `ps2_clk`/`ps2_data`. It is the sending end of the link read by `ps2_keyboard`, used for on-chip keyboard emulation and closed-loop receiver self-test in SimTop. Codes enter through a valid/ready handshake into a small FIFO. Each code is emitted as an 11-bit PS/2 frame, optionally preceded by an automatic `F0` break prefix.

---
 rtl/ps2_kbd_sender.sv | 238 +++++++++++++++++++++++
 tb/tb_ps2_kbd_sender.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_sender.sv
// ps2_kbd_sender: PS/2 device-side transmitter for keyboard scan codes.
// Codes enter through a valid/ready handshake into a small FIFO. Each code is
// sent as an 11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1.
//
// Optional feature macro: PS2_TX_BREAK_EN
//   defined     - FIFO entries carry a break flag; a flagged code is sent as
//                 an F0 frame followed directly by the code frame.
//   not defined - in_break is ignored and every push emits exactly one frame.
//
// Ports:
//   clock        sole clock, all logic on posedge
//   reset        synchronous, active-high
//   in_valid     scan code offered
//   in_ready     FIFO not full (transfer on in_valid && in_ready)
//   in_code      scan code
//   in_break     key-release request (only with PS2_TX_BREAK_EN)
//   ps2_clk      PS/2 clock, idle high
//   ps2_data     PS/2 data, idle high
//   busy         FIFO non-empty or transmitter not idle
//   frames_sent  completed frame count, wraps 255 -> 0
module ps2_kbd_sender #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYC    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_code,
  input  logic       in_break,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic [7:0] frames_sent
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = $clog2(2 * CLK_DIV);
  localparam int unsigned GW = $clog2(GAP_CYC) + 1;
  localparam int unsigned BITS = 11;
`ifdef PS2_TX_BREAK_EN
  localparam int unsigned EW = 9;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
`else
  localparam int unsigned EW = 8;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  // Bits following the start bit: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame_tail(input logic [7:0] code);
    return {1'b1, ~^code, code};
  endfunction

  state_t          state;
  logic [PW-1:0]   phase;
  logic [3:0]      bit_idx;
  logic [GW-1:0]   gap_cnt;
  logic [9:0]      shreg;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;

  logic            push_c;
  logic            pop_c;
  logic            bit_end_c;
  logic            gap_end_c;
  logic            to_idle_c;
  logic [EW-1:0]   head_c;
  logic [EW-1:0]   wr_entry_c;

`ifdef PS2_TX_BREAK_EN
  logic            pend_valid;
  logic [7:0]      pend_code;
  assign wr_entry_c = {in_break, in_code};
`else
  logic            unused_break;
  assign unused_break = in_break;
  assign wr_entry_c   = in_code;
`endif

  // in_ready is the registered !full, so it doubles as the push qualifier.
  assign push_c    = in_valid && in_ready;
  assign pop_c     = (state == S_IDLE) && (count != '0);
  assign head_c    = mem[rd_ptr];
  assign bit_end_c = (phase == PW'(2 * CLK_DIV - 1));
  assign gap_end_c = (gap_cnt == GW'(GAP_CYC - 1));

  // The FSM is headed for IDLE next cycle; feeds the registered busy flag.
  always_comb begin
    to_idle_c = 1'b0;
    if (state == S_IDLE && count == '0) begin
      to_idle_c = 1'b1;
    end
`ifdef PS2_TX_BREAK_EN
    if (state == S_GAP && gap_end_c && !pend_valid) begin
      to_idle_c = 1'b1;
    end
`else
    if (state == S_GAP && gap_end_c) begin
      to_idle_c = 1'b1;
    end
`endif
  end

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    if (push_c && !pop_c) begin
      count_next = count + CW'(1);
    end else if (!push_c && pop_c) begin
      count_next = count - CW'(1);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem[wr_ptr] <= wr_entry_c;
    end
  end

  // Transmit FSM, FIFO pointers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      phase       <= '0;
      bit_idx     <= '0;
      gap_cnt     <= '0;
      shreg       <= '1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      ps2_clk     <= 1'b1;
      ps2_data    <= 1'b1;
      frames_sent <= '0;
`ifdef PS2_TX_BREAK_EN
      pend_valid  <= 1'b0;
      pend_code   <= '0;
`endif
    end else begin
      count    <= count_next;
      in_ready <= (count_next != CW'(FIFO_DEPTH));
      busy     <= (count_next != '0) || !to_idle_c;
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case (state)
        S_IDLE: begin
          if (pop_c) begin
            state    <= S_SEND;
            phase    <= '0;
            bit_idx  <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b0;
`ifdef PS2_TX_BREAK_EN
            if (head_c[8]) begin
              shreg      <= frame_tail(BREAK_CODE);
              pend_code  <= head_c[7:0];
              pend_valid <= 1'b1;
            end else begin
              shreg <= frame_tail(head_c[7:0]);
            end
`else
            shreg <= frame_tail(head_c);
`endif
          end
        end

        S_SEND: begin
          if (bit_end_c) begin
            if (bit_idx == 4'(BITS - 1)) begin
              // Last cycle of the stop bit: frame complete.
              state       <= S_GAP;
              gap_cnt     <= '0;
              ps2_clk     <= 1'b1;
              ps2_data    <= 1'b1;
              frames_sent <= frames_sent + 8'd1;
            end else begin
              // Data changes only at the start of a bit, with the clock high.
              bit_idx  <= bit_idx + 4'd1;
              phase    <= '0;
              ps2_clk  <= 1'b1;
              ps2_data <= shreg[0];
              shreg    <= {1'b1, shreg[9:1]};
            end
          end else begin
            phase   <= phase + PW'(1);
            ps2_clk <= (phase < PW'(CLK_DIV - 1));
          end
        end

        S_GAP: begin
          if (gap_end_c) begin
`ifdef PS2_TX_BREAK_EN
            // A code held behind an F0 prefix starts without an IDLE cycle.
            if (pend_valid) begin
              state      <= S_SEND;
              phase      <= '0;
              bit_idx    <= '0;
              ps2_clk    <= 1'b1;
              ps2_data   <= 1'b0;
              shreg      <= frame_tail(pend_code);
              pend_valid <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_sender.sv
// Directed bench for ps2_kbd_sender: reset state, single frame with latency,
// back-to-back spacing, FIFO fill/backpressure, break handling and mid-frame
// reset. Frames are reassembled from ps2_data sampled at ps2_clk falling edges.
module tb_ps2_kbd_sender;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_CYC    = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int          BUDGET     = 3000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_break = 1'b0;
  logic [7:0] in_code = 8'h00;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [7:0] frames_sent;

  int vectors = 0;
  int miscompares = 0;
  int exp_sent = 0;

  ps2_kbd_sender #(
    .CLK_DIV   (CLK_DIV),
    .GAP_CYC   (GAP_CYC),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_break   (in_break),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clock = ~clock;

  // Receiver model: bit 0 of each captured word is the start bit.
  logic        prev_clk = 1'b1;
  int          nbits = 0;
  logic [10:0] fbits = '0;
  logic [10:0] frames_q[$];

  always @(negedge clock) begin
    if (reset) begin
      nbits    = 0;
      prev_clk = 1'b1;
    end else begin
      if (prev_clk && !ps2_clk) begin
        fbits[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          frames_q.push_back(fbits);
          nbits = 0;
        end
      end
      prev_clk = ps2_clk;
    end
  end

  function automatic logic [10:0] exp_frame(input logic [7:0] c);
    return {1'b1, ~^c, c, 1'b0};
  endfunction

  // All tasks start and end on a negedge.
  task automatic push(input logic [7:0] c, input logic b);
    int t = 0;
    while (!in_ready && t < BUDGET) begin
      @(negedge clock);
      t++;
    end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL push_ready: in_ready=%b after %0d cycles, required 1", in_ready, t);
    end
    in_valid = 1'b1;
    in_code  = c;
    in_break = b;
    @(negedge clock);
    in_valid = 1'b0;
    in_break = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames_q.size() < n && t < BUDGET) begin
      @(negedge clock);
      t++;
    end
    vectors++;
    if (frames_q.size() < n) begin
      miscompares++;
      $display("FAIL wait_frames: got %0d frames, required %0d", frames_q.size(), n);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < BUDGET) begin
      @(negedge clock);
      t++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_idle: busy=%b, required 0", busy);
    end
  endtask

  // From the current clock-low stop-bit half: length of the next ps2_clk high
  // stretch, and how many of its cycles pass before the start bit appears.
  task automatic measure_gap(output int hi, output int lead);
    int t = 0;
    hi = 0;
    lead = -1;
    while (ps2_clk !== 1'b1 && t < BUDGET) begin
      @(negedge clock);
      t++;
    end
    while (ps2_clk === 1'b1 && hi < 200) begin
      if (ps2_data === 1'b0 && lead < 0) lead = hi;
      hi++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors += 5;
    if (ps2_clk !== 1'b1) begin miscompares++; $display("FAIL reset_clk: got %b, required 1", ps2_clk); end
    if (ps2_data !== 1'b1) begin miscompares++; $display("FAIL reset_data: got %b, required 1", ps2_data); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, required 1", in_ready); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (frames_sent !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d, required 0", frames_sent); end
    reset = 1'b0;
    exp_sent = 0;
    @(negedge clock);
  endtask

  task automatic test_single();
    int base = frames_q.size();
    push(8'h1C, 1'b0);
    // Cycle t+1: popped this cycle, start bit not yet on the line.
    vectors += 2;
    if (ps2_data !== 1'b1) begin miscompares++; $display("FAIL single_t1_data: got %b, required 1", ps2_data); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL single_t1_busy: got %b, required 1", busy); end
    @(negedge clock);
    vectors += 2;
    if (ps2_data !== 1'b0) begin miscompares++; $display("FAIL single_start_data: got %b, required 0", ps2_data); end
    if (ps2_clk !== 1'b1) begin miscompares++; $display("FAIL single_start_clk: got %b, required 1", ps2_clk); end
    repeat (CLK_DIV - 1) @(negedge clock);
    vectors++;
    if (ps2_clk !== 1'b1) begin miscompares++; $display("FAIL single_clk_high_end: got %b, required 1", ps2_clk); end
    @(negedge clock);
    vectors++;
    if (ps2_clk !== 1'b0) begin miscompares++; $display("FAIL single_first_fall: got %b, required 0", ps2_clk); end
    wait_frames(base + 1);
    wait_idle();
    exp_sent++;
    vectors += 4;
    if (frames_q[base] !== 11'h438) begin miscompares++; $display("FAIL single_frame: got %h, required 438", frames_q[base]); end
    if (frames_sent !== 8'(exp_sent)) begin miscompares++; $display("FAIL single_count: got %0d, required %0d", frames_sent, exp_sent); end
    if (ps2_clk !== 1'b1) begin miscompares++; $display("FAIL single_idle_clk: got %b, required 1", ps2_clk); end
    if (ps2_data !== 1'b1) begin miscompares++; $display("FAIL single_idle_data: got %b, required 1", ps2_data); end
  endtask

  task automatic test_back_to_back();
    int base = frames_q.size();
    int hi;
    int lead;
    push(8'hAA, 1'b0);
    push(8'h55, 1'b0);
    wait_frames(base + 1);
    measure_gap(hi, lead);
    wait_frames(base + 2);
    wait_idle();
    exp_sent += 2;
    vectors += 5;
    if (lead !== GAP_CYC + 1) begin miscompares++; $display("FAIL b2b_idle_cycles: got %0d, required %0d", lead, GAP_CYC + 1); end
    if (hi !== GAP_CYC + 1 + CLK_DIV) begin miscompares++; $display("FAIL b2b_clk_high: got %0d, required %0d", hi, GAP_CYC + 1 + CLK_DIV); end
    if (frames_q[base] !== 11'h754) begin miscompares++; $display("FAIL b2b_frame_aa: got %h, required 754", frames_q[base]); end
    if (frames_q[base + 1] !== 11'h6AA) begin miscompares++; $display("FAIL b2b_frame_55: got %h, required 6aa", frames_q[base + 1]); end
    if (frames_sent !== 8'(exp_sent)) begin miscompares++; $display("FAIL b2b_count: got %0d, required %0d", frames_sent, exp_sent); end
  endtask

  task automatic test_fill();
    logic [7:0] codes [5];
    logic [9:0] exp_ready;
    int base = frames_q.size();
    int acc = 0;
    int t = 0;
    codes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
    exp_ready = 10'b00000_11111;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (in_ready !== exp_ready[i]) begin
        miscompares++;
        $display("FAIL fill_ready cycle %0d: got %b, required %b", i, in_ready, exp_ready[i]);
      end
      in_valid = 1'b1;
      in_code  = (acc < 5) ? codes[acc] : 8'hEE;
      if (in_ready) acc++;
      @(negedge clock);
    end
    in_valid = 1'b0;
    vectors++;
    if (acc !== 5) begin miscompares++; $display("FAIL fill_accepted: got %0d, required 5", acc); end
    // in_ready returns the cycle after the second pop, with that start bit.
    while (!in_ready && t < BUDGET) begin
      @(negedge clock);
      t++;
    end
    vectors += 3;
    if (ps2_data !== 1'b0) begin miscompares++; $display("FAIL fill_rise_data: got %b, required 0", ps2_data); end
    if (ps2_clk !== 1'b1) begin miscompares++; $display("FAIL fill_rise_clk: got %b, required 1", ps2_clk); end
    if (frames_q.size() !== base + 1) begin miscompares++; $display("FAIL fill_rise_frames: got %0d, required %0d", frames_q.size(), base + 1); end
    wait_frames(base + 5);
    wait_idle();
    exp_sent += 5;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (frames_q[base + i] !== exp_frame(codes[i])) begin
        miscompares++;
        $display("FAIL fill_frame %0d: got %h, required %h", i, frames_q[base + i], exp_frame(codes[i]));
      end
    end
    vectors += 2;
    if (frames_q.size() !== base + 5) begin miscompares++; $display("FAIL fill_extra: got %0d frames, required %0d", frames_q.size(), base + 5); end
    if (frames_sent !== 8'(exp_sent)) begin miscompares++; $display("FAIL fill_count: got %0d, required %0d", frames_sent, exp_sent); end
  endtask

  task automatic test_break();
    int base = frames_q.size();
`ifdef PS2_TX_BREAK_EN
    int hi;
    int lead;
    push(8'h1C, 1'b1);
    wait_frames(base + 1);
    measure_gap(hi, lead);
    wait_frames(base + 2);
    wait_idle();
    exp_sent += 2;
    vectors += 5;
    if (frames_q[base] !== 11'h7E0) begin miscompares++; $display("FAIL break_f0: got %h, required 7e0", frames_q[base]); end
    if (frames_q[base + 1] !== 11'h438) begin miscompares++; $display("FAIL break_code: got %h, required 438", frames_q[base + 1]); end
    if (lead !== GAP_CYC) begin miscompares++; $display("FAIL break_gap: got %0d, required %0d", lead, GAP_CYC); end
    if (hi !== GAP_CYC + CLK_DIV) begin miscompares++; $display("FAIL break_clk_high: got %0d, required %0d", hi, GAP_CYC + CLK_DIV); end
    if (frames_sent !== 8'(exp_sent)) begin miscompares++; $display("FAIL break_count: got %0d, required %0d", frames_sent, exp_sent); end
`else
    push(8'h1C, 1'b1);
    wait_frames(base + 1);
    wait_idle();
    repeat (2 * CLK_DIV) @(negedge clock);
    exp_sent += 1;
    vectors += 3;
    if (frames_q[base] !== 11'h438) begin miscompares++; $display("FAIL nobreak_code: got %h, required 438", frames_q[base]); end
    if (frames_q.size() !== base + 1) begin miscompares++; $display("FAIL nobreak_extra: got %0d frames, required %0d", frames_q.size(), base + 1); end
    if (frames_sent !== 8'(exp_sent)) begin miscompares++; $display("FAIL nobreak_count: got %0d, required %0d", frames_sent, exp_sent); end
`endif
  endtask

  task automatic test_reset_mid();
    int base = frames_q.size();
    int t = 0;
    push(8'h1C, 1'b0);
    while (nbits < 4 && t < BUDGET) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_sent = 0;
    vectors += 6;
    if (ps2_clk !== 1'b1) begin miscompares++; $display("FAIL midreset_clk: got %b, required 1", ps2_clk); end
    if (ps2_data !== 1'b1) begin miscompares++; $display("FAIL midreset_data: got %b, required 1", ps2_data); end
    if (frames_sent !== 8'd0) begin miscompares++; $display("FAIL midreset_count: got %0d, required 0", frames_sent); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b, required 0", busy); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midreset_ready: got %b, required 1", in_ready); end
    if (frames_q.size() !== base) begin miscompares++; $display("FAIL midreset_partial: got %0d frames, required %0d", frames_q.size(), base); end
    push(8'h1B, 1'b0);
    wait_frames(base + 1);
    wait_idle();
    exp_sent++;
    vectors += 2;
    if (frames_q[base] !== 11'h636) begin miscompares++; $display("FAIL midreset_frame: got %h, required 636", frames_q[base]); end
    if (frames_sent !== 8'(exp_sent)) begin miscompares++; $display("FAIL midreset_after_count: got %0d, required %0d", frames_sent, exp_sent); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clock);
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_break();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
